// File: rtl/rice_core_pkg.sv
// rice_core_pkg: shared types for the rice core execute-stage units.
//   rice_core_div_operation : divide-group decode {rs_signed, rd_remainder}
//   rice_core_div_state     : iterative divider control states
package rice_core_pkg;

    typedef struct packed {
        logic rs_signed;     // DIV/REM (1) vs DIVU/REMU (0)
        logic rd_remainder;  // REM/REMU (1) vs DIV/DIVU (0)
    } rice_core_div_operation;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } rice_core_div_state;

endpackage

// File: rtl/rice_core_div.sv
// rice_core_div: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_valid            request level, held by execute until o_result_valid
//   i_flush            aborts any operation in progress, blocks a start
//   i_rs1_value        dividend
//   i_rs2_value        divisor
//   i_div_operation    {rs_signed, rd_remainder}, sampled at start only
//   o_result_valid     one-cycle result strobe
//   o_result           quotient or remainder, meaningful with the strobe
//
// Latency is XLEN+2 cycles from the start cycle to the strobe.
// Optional macro RICE_CORE_DIV_EARLY_OUT_EN: divide-by-zero and signed
// overflow skip CALC and strobe after 2 cycles; results are unchanged.
module rice_core_div
    import rice_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic                   i_flush,
    input  logic [XLEN-1:0]        i_rs1_value,
    input  logic [XLEN-1:0]        i_rs2_value,
    input  rice_core_div_operation i_div_operation,
    output logic                   o_result_valid,
    output logic [XLEN-1:0]        o_result
);

    localparam int              CW      = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] ONE     = XLEN'(1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
        return (~x) + ONE;
    endfunction

    // |MIN_NEG| wraps back to MIN_NEG, which is the right unsigned magnitude.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? neg(x) : x;
    endfunction

    // One restoring step: returns {rem_next, dvd_next}. The partial
    // remainder is always below the divisor, so XLEN bits hold it between
    // steps; only the shifted value needs the extra bit for the borrow.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                   input logic [XLEN-1:0] dvd,
                                                   input logic [XLEN-1:0] dvs);
        logic [XLEN:0] rem_sh;
        logic [XLEN:0] diff;
        rem_sh = {rem, dvd[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs};
        if (diff[XLEN])
            return {rem_sh[XLEN-1:0], dvd[XLEN-2:0], 1'b0};
        return {diff[XLEN-1:0], dvd[XLEN-2:0], 1'b1};
    endfunction

    rice_core_div_state state;
    logic [CW-1:0]      count;
    logic [XLEN-1:0]    rem;      // partial remainder
    logic [XLEN-1:0]    dvd;      // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]    dvs;      // divisor magnitude
    logic [XLEN-1:0]    rs1_q;    // original dividend for the divide-by-zero remainder
    logic               q_neg;
    logic               r_neg;
    logic               rd_rem;
    logic               div_zero;
    logic               overflow;
    logic               valid_q;

    logic               start;
    logic               sgn;
    logic               start_dz;
    logic               start_ovf;
    logic [2*XLEN-1:0]  step;
    logic [XLEN-1:0]    fix_q;
    logic [XLEN-1:0]    fix_r;
    logic [XLEN-1:0]    fix_result;

    assign sgn       = i_div_operation.rs_signed;
    assign start     = (state == IDLE) && i_valid && !i_flush;
    assign start_dz  = (i_rs2_value == '0);
    assign start_ovf = sgn && (i_rs1_value == MIN_NEG) && (i_rs2_value == '1);
    assign step      = div_step(rem, dvd, dvs);

    always_comb begin
        fix_q = q_neg ? neg(dvd) : dvd;
        fix_r = r_neg ? neg(rem) : rem;
        if (div_zero) begin
            fix_q = '1;
            fix_r = rs1_q;
        end else if (overflow) begin
            fix_q = MIN_NEG;
            fix_r = '0;
        end
        fix_result = rd_rem ? fix_r : fix_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            count    <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rs1_q    <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            rd_rem   <= 1'b0;
            div_zero <= 1'b0;
            overflow <= 1'b0;
            valid_q  <= 1'b0;
            o_result <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rem      <= '0;
                        dvd      <= sgn ? abs_val(i_rs1_value) : i_rs1_value;
                        dvs      <= sgn ? abs_val(i_rs2_value) : i_rs2_value;
                        rs1_q    <= i_rs1_value;
                        q_neg    <= sgn && (i_rs1_value[XLEN-1] ^ i_rs2_value[XLEN-1]);
                        r_neg    <= sgn && i_rs1_value[XLEN-1];
                        rd_rem   <= i_div_operation.rd_remainder;
                        div_zero <= start_dz;
                        overflow <= start_ovf;
                        count    <= CW'(XLEN);
`ifdef RICE_CORE_DIV_EARLY_OUT_EN
                        state    <= (start_dz || start_ovf) ? FIX : CALC;
`else
                        state    <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (i_flush) begin
                        state <= IDLE;
                    end else begin
                        {rem, dvd} <= step;
                        count      <= count - CW'(1);
                        if (count == CW'(1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (i_flush) begin
                        state <= IDLE;
                    end else begin
                        o_result <= fix_result;
                        valid_q  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A flush landing on the strobe cycle must suppress the result.
    assign o_result_valid = valid_q && !i_flush;

endmodule
